dac_spi_tx: RTL and testbench



---
 rtl/synth_pkg.sv | 27 ++
 rtl/dac_spi_tx_if.sv | 14 +
 rtl/dac_sclk_tick.sv | 29 ++
 rtl/dac_spi_tx.sv | 155 +++++++++++++++
 tb/tb_dac_spi_tx.sv | 417 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/synth_pkg.sv
// Shared definitions for the synth DAC output path: frame geometry,
// serialiser state encoding and the default DAC command byte.
package synth_pkg;

  localparam int FRAME_W  = 24;
  localparam int CMD_W    = 8;
  localparam int SAMPLE_W = FRAME_W - CMD_W;

  localparam logic [CMD_W-1:0] DEFAULT_CMD = 8'h00;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEAD,
    ST_SHIFT_H,
    ST_SHIFT_L,
    ST_TRAIL
  } dac_state_t;

  // Command byte in the top bits, sample below, sent MSB first.
  function automatic logic [FRAME_W-1:0] build_frame(
    input logic [CMD_W-1:0]    cmd,
    input logic [SAMPLE_W-1:0] sample
  );
    return {cmd, sample};
  endfunction

endpackage

// File: rtl/dac_spi_tx_if.sv
// Sample-stream handshake into the DAC serialiser: the producer drives
// sample/valid, the serialiser returns ready and a dropped-sample pulse.
interface dac_spi_tx_if;
  import synth_pkg::*;

  logic [SAMPLE_W-1:0] sample;
  logic                valid;
  logic                ready;
  logic                overrun;

  modport master (output sample, output valid, input ready, input overrun);
  modport slave  (input sample, input valid, output ready, output overrun);

endinterface

// File: rtl/dac_sclk_tick.sv
// Half-period timebase: counts 0..CLK_DIV-1 and flags the last count.
// A synchronous clear restarts the half-period from zero.
module dac_sclk_tick #(
  parameter int CLK_DIV = 5
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_clr,
  output logic o_tick
);

  localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [CNT_W-1:0] r_cnt;

  assign o_tick = (r_cnt == CNT_W'(CLK_DIV - 1));

  // Free-running half-period counter, wrapping on the tick.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n || i_clr) begin
      r_cnt <= '0;
    end else if (o_tick) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/dac_spi_tx.sv
// Serialises 16-bit samples into 24-bit {CMD, sample} SPI write frames
// (CPOL=0, MSB first) with a one-entry holding register in front so the
// next sample can queue while the current frame shifts out.
module dac_spi_tx
  import synth_pkg::*;
#(
  parameter int               CLK_DIV = 5,
  parameter logic [CMD_W-1:0] CMD     = DEFAULT_CMD,
  parameter int               CS_GAP  = 2
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  dac_spi_tx_if.slave  bus,
  output logic         o_busy,
  output logic         o_dac_sclk,
  output logic         o_dac_mosi,
  output logic         o_dac_cs_n
);

  localparam int GAP_W = (CS_GAP > 1) ? $clog2(CS_GAP) : 1;

  dac_state_t            r_state;
  logic [FRAME_W-1:0]    r_shift;
  logic [SAMPLE_W-1:0]   r_hold;
  logic                  r_hold_full;
  logic [4:0]            r_bit_cnt;
  logic [GAP_W-1:0]      r_gap_cnt;
  logic                  r_overrun;
  logic                  r_busy;
  logic                  r_sclk;
  logic                  r_mosi;
  logic                  r_cs_n;

  logic                  w_tick;
  logic                  w_tick_clr;
  logic                  w_accept;
  logic                  w_gap_done;
  logic                  w_load;
  logic [FRAME_W-1:0]    w_next_frame;

  // The timebase idles at zero so LEAD always gets a full half-period;
  // every other state change happens on a tick, where it wraps anyway.
  assign w_tick_clr = (r_state == ST_IDLE);

  dac_sclk_tick #(
    .CLK_DIV (CLK_DIV)
  ) u_tick (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_clr   (w_tick_clr),
    .o_tick  (w_tick)
  );

  assign w_accept   = bus.valid && !r_hold_full;
  assign w_gap_done = w_tick && (r_gap_cnt == GAP_W'(CS_GAP - 1));

  // A sample accepted on TRAIL's last edge bypasses the hold register so
  // the next frame still starts straight from TRAIL.
  assign w_load = ((r_state == ST_IDLE) && r_hold_full) ||
                  ((r_state == ST_TRAIL) && w_gap_done && (r_hold_full || w_accept));

  assign w_next_frame = build_frame(CMD, r_hold_full ? r_hold : bus.sample);

  assign bus.ready   = !r_hold_full;
  assign bus.overrun = r_overrun;
  assign o_busy      = r_busy;
  assign o_dac_sclk  = r_sclk;
  assign o_dac_mosi  = r_mosi;
  assign o_dac_cs_n  = r_cs_n;

  // Hold register, frame FSM and registered SPI pins.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state     <= ST_IDLE;
      r_shift     <= '0;
      r_hold      <= '0;
      r_hold_full <= 1'b0;
      r_bit_cnt   <= '0;
      r_gap_cnt   <= '0;
      r_overrun   <= 1'b0;
      r_busy      <= 1'b0;
      r_sclk      <= 1'b0;
      r_mosi      <= 1'b0;
      r_cs_n      <= 1'b1;
    end else begin
      r_overrun <= bus.valid && r_hold_full;

      if (w_accept) begin
        r_hold      <= bus.sample;
        r_hold_full <= 1'b1;
      end

      if (w_load) begin
        r_state     <= ST_LEAD;
        r_shift     <= w_next_frame;
        r_hold_full <= 1'b0;
        r_busy      <= 1'b1;
        r_cs_n      <= 1'b0;
        r_sclk      <= 1'b0;
        r_mosi      <= w_next_frame[FRAME_W-1];
      end else begin
        case (r_state)
          ST_IDLE: begin
            r_busy <= 1'b0;
          end
          ST_LEAD: begin
            if (w_tick) begin
              r_state   <= ST_SHIFT_H;
              r_bit_cnt <= 5'(FRAME_W - 1);
              r_sclk    <= 1'b1;
              r_mosi    <= r_shift[FRAME_W-1];
            end
          end
          ST_SHIFT_H: begin
            if (w_tick) begin
              r_state <= ST_SHIFT_L;
              r_sclk  <= 1'b0;
            end
          end
          ST_SHIFT_L: begin
            if (w_tick) begin
              if (r_bit_cnt == '0) begin
                r_state   <= ST_TRAIL;
                r_cs_n    <= 1'b1;
                r_mosi    <= 1'b0;
                r_gap_cnt <= '0;
              end else begin
                r_state   <= ST_SHIFT_H;
                r_bit_cnt <= r_bit_cnt - 5'd1;
                r_sclk    <= 1'b1;
                r_mosi    <= r_shift[r_bit_cnt - 5'd1];
              end
            end
          end
          ST_TRAIL: begin
            if (w_gap_done) begin
              r_state <= ST_IDLE;
              r_busy  <= 1'b0;
            end else if (w_tick) begin
              r_gap_cnt <= r_gap_cnt + GAP_W'(1);
            end
          end
          default: begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
            r_cs_n  <= 1'b1;
            r_sclk  <= 1'b0;
            r_mosi  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_dac_spi_tx.sv
// Bench for dac_spi_tx: a default-timing instance (CLK_DIV=5, CS_GAP=2) and
// a fastest-timing instance (CLK_DIV=1, CS_GAP=1), both with CMD=8'h30.
// A pin monitor rebuilds each frame from falling-sclk samples; expected
// frames are queued at accept time and matched against monitored frames.
module tb_dac_spi_tx;

  localparam int DIV0 = 5;
  localparam int GAP0 = 2;
  localparam int DIV1 = 1;
  localparam int GAP1 = 1;

  typedef struct {
    int          inst;
    logic [23:0] frame;
    int          low;
    int          pulses;
    bit          width_ok;
    longint      start;
  } rec_t;

  typedef struct {
    int          inst;
    logic [23:0] frame;
  } exp_t;

  logic   clk = 1'b0;
  logic   rst_n = 1'b0;
  longint cyc = 0;
  int     n_cmp = 0;
  int     n_bad = 0;

  rec_t mon_q[$];
  exp_t exp_q[$];

  dac_spi_tx_if bus0 ();
  dac_spi_tx_if bus1 ();

  logic busy0, sclk0, mosi0, cs0;
  logic busy1, sclk1, mosi1, cs1;

  dac_spi_tx #(.CLK_DIV(DIV0), .CMD(8'h30), .CS_GAP(GAP0)) dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .bus        (bus0),
    .o_busy     (busy0),
    .o_dac_sclk (sclk0),
    .o_dac_mosi (mosi0),
    .o_dac_cs_n (cs0)
  );

  dac_spi_tx #(.CLK_DIV(DIV1), .CMD(8'h30), .CS_GAP(GAP1)) dut1 (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .bus        (bus1),
    .o_busy     (busy1),
    .o_dac_sclk (sclk1),
    .o_dac_mosi (mosi1),
    .o_dac_cs_n (cs1)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  logic cs_w[2], sclk_w[2], mosi_w[2];
  assign cs_w[0] = cs0;   assign cs_w[1] = cs1;
  assign sclk_w[0] = sclk0; assign sclk_w[1] = sclk1;
  assign mosi_w[0] = mosi0; assign mosi_w[1] = mosi1;

  logic        m_in[2];
  logic        m_prev[2];
  logic [23:0] m_sh[2];
  int          m_low[2], m_pul[2], m_run[2];
  bit          m_ok[2];
  longint      m_start[2];
  bit          abort_frame[2];
  rec_t        m_rec;

  initial begin
    for (int k = 0; k < 2; k++) begin
      m_in[k] = 1'b0; m_prev[k] = 1'b0; m_sh[k] = '0;
      m_low[k] = 0; m_pul[k] = 0; m_run[k] = 0; m_ok[k] = 1'b1;
      m_start[k] = 0; abort_frame[k] = 1'b0;
    end
  end

  // Pin monitor: rebuilds frames from the pins, measures cs_n low time,
  // sclk pulse count and that every sclk level lasts exactly CLK_DIV.
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (cs_w[k] === 1'b0) begin
        if (!m_in[k]) begin
          m_in[k] = 1'b1; m_low[k] = 0; m_pul[k] = 0; m_sh[k] = '0;
          m_run[k] = 0; m_ok[k] = 1'b1; m_prev[k] = 1'b0; m_start[k] = cyc;
        end
        m_low[k]++;
        if (sclk_w[k] === m_prev[k]) begin
          m_run[k]++;
        end else begin
          if (m_run[k] != ((k == 0) ? DIV0 : DIV1)) m_ok[k] = 1'b0;
          m_run[k] = 1;
          if (m_prev[k] && !sclk_w[k]) begin
            m_pul[k]++;
            m_sh[k] = {m_sh[k][22:0], mosi_w[k]};
          end
        end
        m_prev[k] = sclk_w[k];
      end else if (m_in[k]) begin
        m_in[k] = 1'b0;
        if (m_run[k] != ((k == 0) ? DIV0 : DIV1) || m_prev[k]) m_ok[k] = 1'b0;
        if (abort_frame[k]) begin
          abort_frame[k] = 1'b0;
        end else begin
          m_rec.inst = k; m_rec.frame = m_sh[k]; m_rec.low = m_low[k];
          m_rec.pulses = m_pul[k]; m_rec.width_ok = m_ok[k]; m_rec.start = m_start[k];
          mon_q.push_back(m_rec);
        end
      end
    end
  end

  function automatic logic get_ready(input int inst);
    return (inst == 0) ? bus0.ready : bus1.ready;
  endfunction

  // Waits (bounded) for ready, then presents one sample for one edge.
  // acc is the cycle count just after the accepting edge.
  task automatic send(input int inst, input logic [15:0] s,
                      output longint acc, output bit ok);
    ok = 1'b0;
    acc = 0;
    for (int t = 0; t < 2000; t++) begin
      @(negedge clk);
      if (get_ready(inst) === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) return;
    if (inst == 0) begin bus0.sample = s; bus0.valid = 1'b1; end
    else begin bus1.sample = s; bus1.valid = 1'b1; end
    @(posedge clk);
    #1;
    acc = cyc;
    bus0.valid = 1'b0;
    bus1.valid = 1'b0;
  endtask

  task automatic wait_rec(input int limit, output rec_t r, output bit ok);
    ok = 1'b0;
    r = '{default: 0};
    for (int t = 0; t < limit; t++) begin
      if (mon_q.size() > 0) begin
        r = mon_q.pop_front();
        ok = 1'b1;
        return;
      end
      @(negedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int t = 0; t < 100; t++) begin
      @(negedge clk);
      #1;
      n_cmp++;
      if ({cs0, sclk0, mosi0, bus0.ready, busy0} !== 5'b10010) begin
        n_bad++;
        $display("FAIL reset_idle0 t=%0d got cs/sclk/mosi/rdy/busy=%b want 10010", t,
                 {cs0, sclk0, mosi0, bus0.ready, busy0});
      end
      n_cmp++;
      if ({cs1, sclk1, mosi1, bus1.ready, busy1} !== 5'b10010) begin
        n_bad++;
        $display("FAIL reset_idle1 t=%0d got cs/sclk/mosi/rdy/busy=%b want 10010", t,
                 {cs1, sclk1, mosi1, bus1.ready, busy1});
      end
    end
  endtask

  task automatic check_frame(input string name, input rec_t r, input bit ok,
                             input int want_low);
    exp_t e;
    n_cmp++;
    if (!ok) begin
      n_bad++;
      $display("FAIL %s timeout: no frame seen", name);
      return;
    end
    if (exp_q.size() == 0) begin
      n_bad++;
      $display("FAIL %s unexpected frame %h", name, r.frame);
      return;
    end
    e = exp_q.pop_front();
    if (r.inst !== e.inst || r.frame !== e.frame) begin
      n_bad++;
      $display("FAIL %s data got inst%0d %h want inst%0d %h", name, r.inst, r.frame, e.inst, e.frame);
    end
    n_cmp++;
    if (r.low != want_low) begin
      n_bad++;
      $display("FAIL %s cs_low got %0d want %0d", name, r.low, want_low);
    end
    n_cmp++;
    if (r.pulses != 24) begin
      n_bad++;
      $display("FAIL %s sclk_pulses got %0d want 24", name, r.pulses);
    end
    n_cmp++;
    if (r.width_ok !== 1'b1) begin
      n_bad++;
      $display("FAIL %s sclk_width got irregular want %0d/%0d", name,
               (r.inst == 0) ? DIV0 : DIV1, (r.inst == 0) ? DIV0 : DIV1);
    end
  endtask

  task automatic test_single();
    longint acc;
    bit ok, rok;
    rec_t r;
    send(0, 16'hA5C3, acc, ok);
    exp_q.push_back('{0, 24'h30A5C3});
    n_cmp++;
    if (!ok) begin n_bad++; $display("FAIL single_accept got no ready want ready"); end
    wait_rec(1000, r, rok);
    check_frame("single", r, rok, 49 * DIV0);
    n_cmp++;
    if (rok && (r.start - acc) != 1) begin
      n_bad++;
      $display("FAIL single_latency got %0d want 1 edge after accept edge", r.start - acc);
    end
    for (int t = 0; t < 10; t++) begin
      @(negedge clk);
      #1;
      n_cmp++;
      if (cs0 !== 1'b1) begin
        n_bad++;
        $display("FAIL single_gap t=%0d cs_n got %b want 1", t, cs0);
      end
    end
  endtask

  task automatic test_back_to_back();
    longint acc1, acc2, rise;
    bit ok1, ok2, rok1, rok2, rose;
    rec_t r1, r2;
    send(0, 16'h0001, acc1, ok1);
    exp_q.push_back('{0, 24'h300001});
    repeat (20) @(negedge clk);
    send(0, 16'hFFFF, acc2, ok2);
    exp_q.push_back('{0, 24'h30FFFF});
    n_cmp++;
    if (!(ok1 && ok2)) begin n_bad++; $display("FAIL b2b_accept got %b%b want 11", ok1, ok2); end
    rose = 1'b0;
    rise = 0;
    for (int t = 0; t < 600; t++) begin
      @(negedge clk);
      #1;
      if (bus0.ready === 1'b1) begin
        rose = 1'b1;
        rise = cyc;
        break;
      end
    end
    wait_rec(1000, r1, rok1);
    check_frame("b2b_first", r1, rok1, 49 * DIV0);
    wait_rec(1000, r2, rok2);
    check_frame("b2b_second", r2, rok2, 49 * DIV0);
    n_cmp++;
    if (rok1 && rok2 && (r2.start - r1.start) != (49 + GAP0) * DIV0) begin
      n_bad++;
      $display("FAIL b2b_period got %0d want %0d", r2.start - r1.start, (49 + GAP0) * DIV0);
    end
    n_cmp++;
    if (!rose || !rok2 || rise != r2.start) begin
      n_bad++;
      $display("FAIL b2b_ready_rise got cycle %0d want %0d (second load)", rise, r2.start);
    end
  endtask

  task automatic test_overrun();
    longint acc;
    bit ok1, ok2, rok1, rok2;
    int highs;
    rec_t r1, r2;
    send(0, 16'h1111, acc, ok1);
    exp_q.push_back('{0, 24'h301111});
    send(0, 16'h2222, acc, ok2);
    exp_q.push_back('{0, 24'h302222});
    n_cmp++;
    if (!(ok1 && ok2)) begin n_bad++; $display("FAIL ovr_accept got %b%b want 11", ok1, ok2); end
    repeat (3) @(negedge clk);
    n_cmp++;
    if (bus0.ready !== 1'b0) begin
      n_bad++;
      $display("FAIL ovr_ready got %b want 0", bus0.ready);
    end
    bus0.sample = 16'h1234;
    bus0.valid = 1'b1;
    highs = 0;
    for (int t = 0; t < 6; t++) begin
      @(negedge clk);
      bus0.valid = 1'b0;
      #1;
      if (bus0.overrun === 1'b1) highs++;
    end
    n_cmp++;
    if (highs != 1) begin
      n_bad++;
      $display("FAIL ovr_pulse got %0d cycles want 1", highs);
    end
    wait_rec(1000, r1, rok1);
    check_frame("ovr_first", r1, rok1, 49 * DIV0);
    wait_rec(1000, r2, rok2);
    check_frame("ovr_held", r2, rok2, 49 * DIV0);
  endtask

  task automatic test_reset_mid();
    longint acc;
    bit ok1, ok2, ok3, rok, found;
    int falls;
    logic prev;
    rec_t r;
    send(0, 16'h4444, acc, ok1);
    send(0, 16'h7777, acc, ok2);
    falls = 0;
    prev = sclk0;
    found = 1'b0;
    for (int t = 0; t < 1000; t++) begin
      @(negedge clk);
      #1;
      if (prev === 1'b1 && sclk0 === 1'b0) falls++;
      prev = sclk0;
      if (falls == 10) begin
        found = 1'b1;
        break;
      end
    end
    n_cmp++;
    if (!(ok1 && ok2 && found)) begin
      n_bad++;
      $display("FAIL rstmid_setup got acc=%b%b fall10=%b want 111", ok1, ok2, found);
    end
    abort_frame[0] = 1'b1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    n_cmp++;
    if ({cs0, sclk0, bus0.ready, busy0} !== 4'b1010) begin
      n_bad++;
      $display("FAIL rstmid_pins got cs/sclk/rdy/busy=%b want 1010", {cs0, sclk0, bus0.ready, busy0});
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    abort_frame[0] = 1'b0;
    send(0, 16'h8000, acc, ok3);
    exp_q.push_back('{0, 24'h308000});
    n_cmp++;
    if (!ok3) begin n_bad++; $display("FAIL rstmid_accept got no ready want ready"); end
    wait_rec(1000, r, rok);
    check_frame("rstmid_clean", r, rok, 49 * DIV0);
  endtask

  task automatic test_div1();
    longint acc;
    bit ok1, ok2, rok1, rok2;
    rec_t r1, r2;
    send(1, 16'h5A5A, acc, ok1);
    exp_q.push_back('{1, 24'h305A5A});
    send(1, 16'hA5A5, acc, ok2);
    exp_q.push_back('{1, 24'h30A5A5});
    n_cmp++;
    if (!(ok1 && ok2)) begin n_bad++; $display("FAIL div1_accept got %b%b want 11", ok1, ok2); end
    wait_rec(300, r1, rok1);
    check_frame("div1_first", r1, rok1, 49 * DIV1);
    wait_rec(300, r2, rok2);
    check_frame("div1_second", r2, rok2, 49 * DIV1);
    n_cmp++;
    if (rok1 && rok2 && (r2.start - r1.start) != (49 + GAP1) * DIV1) begin
      n_bad++;
      $display("FAIL div1_period got %0d want %0d", r2.start - r1.start, (49 + GAP1) * DIV1);
    end
  endtask

  initial begin
    bus0.sample = '0; bus0.valid = 1'b0;
    bus1.sample = '0; bus1.valid = 1'b0;
    test_reset();
    test_single();
    test_back_to_back();
    test_overrun();
    test_reset_mid();
    test_div1();
    repeat (5) @(negedge clk);
    n_cmp++;
    if (mon_q.size() != 0 || exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL leftover got mon=%0d exp=%0d want 0/0", mon_q.size(), exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got no finish want finish within 50000 cycles");
    $fatal(1, "watchdog");
  end

endmodule
